// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths, HALT opcode, FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_pkg;

    localparam int AW_DEF = 6;
    localparam int IW_DEF = 16;
    localparam int CW_DEF = 16;

    // Opcode in the top nibble of an instruction that stops fetch
    localparam logic [3:0] HALT_OP_DEF = 4'hF;

    // Instruction word loaded into IF/ID on reset
    localparam logic [IW_DEF-1:0] NOP = '0;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC mux and incrementer feeding the PC register input.
// Latency: purely combinational, 0 cycles.
// Backpressure: stall or hold recirculates pc_cur; redirect overrides both.
module next_pc_sel
    import if_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          rst,
    input  logic          br_taken,
    input  logic [AW-1:0] br_target,
    input  logic          stall,
    input  logic          hold,
    input  logic [AW-1:0] pc_cur,
    output logic [AW-1:0] pc_next
);

    // Priority: reset, redirect, stall, halt hold, then sequential increment (wraps naturally)
    always_comb begin
        pc_next = pc_cur + AW'(1);
        if (rst) begin
            pc_next = '0;
        end else if (br_taken) begin
            pc_next = br_target;
        end else if (stall || hold) begin
            pc_next = pc_cur;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: drives imem from pc_cur, picks the next PC, registers the fetched word into IF/ID.
// Latency: pc_cur to ifid_* is 1 cycle; imem_addr and pc_next are combinational.
// Backpressure: stall holds PC and IF/ID; branch flushes IF/ID and redirects; HALT freezes fetch until redirect or reset.
module if_stage
    import if_pkg::*;
#(
    parameter int         AW      = AW_DEF,
    parameter int         IW      = IW_DEF,
    parameter logic [3:0] HALT_OP = HALT_OP_DEF,
    parameter int         CW      = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] pc_cur,
    output logic [AW-1:0] pc_next,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_rdata,
    input  logic          stall,
    input  logic          br_taken,
    input  logic [AW-1:0] br_target,
    output logic [IW-1:0] ifid_instr,
    output logic [AW-1:0] ifid_pc,
    output logic          ifid_valid,
    output logic          halted,
    output logic [CW-1:0] fetch_count
);

    state_t state_q;
    state_t state_d;
    logic   is_halt_op;
    logic   load_instr;
    logic   valid_d;
    logic   pc_hold;

    assign imem_addr  = pc_cur;
    assign is_halt_op = (imem_rdata[IW-1 -: 4] == HALT_OP);
    assign halted     = (state_q == HALTED);

    // PC stays put while halted and also on the cycle the HALT word itself is fetched
    assign pc_hold = (state_q == HALTED) || is_halt_op;

    next_pc_sel #(
        .AW (AW)
    ) u_next_pc_sel (
        .rst       (rst),
        .br_taken  (br_taken),
        .br_target (br_target),
        .stall     (stall),
        .hold      (pc_hold),
        .pc_cur    (pc_cur),
        .pc_next   (pc_next)
    );

    // Next state and IF/ID load decision, same priority as the PC mux
    always_comb begin
        state_d    = state_q;
        load_instr = 1'b0;
        valid_d    = ifid_valid;
        if (br_taken) begin
            state_d = RUN;
            valid_d = 1'b0;
        end else if (stall) begin
            valid_d = ifid_valid;
        end else if (state_q == HALTED) begin
            valid_d = 1'b0;
        end else begin
            load_instr = 1'b1;
            valid_d    = 1'b1;
            if (is_halt_op) begin
                state_d = HALTED;
            end
        end
    end

    // State, IF/ID register and saturating delivered-instruction counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            ifid_instr  <= IW'(NOP);
            ifid_pc     <= '0;
            ifid_valid  <= 1'b0;
            fetch_count <= '0;
        end else begin
            state_q    <= state_d;
            ifid_valid <= valid_d;
            if (load_instr) begin
                ifid_instr <= imem_rdata;
                ifid_pc    <= pc_cur;
                if (fetch_count != {CW{1'b1}}) begin
                    fetch_count <= fetch_count + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  pc_cur = '0;
    logic [5:0]  pc_next;
    logic [5:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        br_taken;
    logic [5:0]  br_target;
    logic [15:0] ifid_instr;
    logic [5:0]  ifid_pc;
    logic        ifid_valid;
    logic        halted;
    logic [15:0] fetch_count;

    int checks = 0;
    int errors = 0;

    if_stage dut (
        .clk         (clk),
        .rst         (rst),
        .pc_cur      (pc_cur),
        .pc_next     (pc_next),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .ifid_instr  (ifid_instr),
        .ifid_pc     (ifid_pc),
        .ifid_valid  (ifid_valid),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    // PC register closing the loop around the fetch stage
    always @(posedge clk) pc_cur <= pc_next;

    // Instruction memory: address 9 holds HALT, everything else 0x1000+addr
    always_comb begin
        if (imem_addr == 6'd9) imem_rdata = 16'hF000;
        else                   imem_rdata = 16'h1000 + {10'd0, imem_addr};
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
        #1;
        checks++; if (pc_next !== 6'd0) begin errors++; $display("FAIL rst_pc_next got %0d exp 0", pc_next); end
        tick();
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", ifid_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b exp 0", halted); end
        checks++; if (fetch_count !== 16'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", fetch_count); end
        checks++; if (ifid_pc !== 6'd0 || ifid_instr !== 16'h0) begin errors++; $display("FAIL rst_ifid got pc=%0d instr=%h exp 0/0000", ifid_pc, ifid_instr); end
        #1;
        checks++; if (pc_next !== 6'd0) begin errors++; $display("FAIL rst_pc_next2 got %0d exp 0", pc_next); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (imem_addr !== 6'd0 || pc_next !== 6'd1) begin errors++; $display("FAIL rel_pc got addr=%0d next=%0d exp 0/1", imem_addr, pc_next); end
    endtask

    task automatic test_seq_fetch;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ifid_pc !== 6'(i) || ifid_instr !== 16'h1000 + 16'(i) || ifid_valid !== 1'b1) begin
                errors++; $display("FAIL seq_%0d got pc=%0d instr=%h v=%b exp %0d/%h/1", i, ifid_pc, ifid_instr, ifid_valid, i, 16'h1000 + 16'(i));
            end
        end
        checks++; if (fetch_count !== 16'd3) begin errors++; $display("FAIL seq_count got %0d exp 3", fetch_count); end
    endtask

    task automatic test_stall;
        tick(); tick();
        // now pc_cur=5, IF/ID holds pc 4 / 0x1004, count 5
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (pc_next !== 6'd5) begin errors++; $display("FAIL stall_pc_next_%0d got %0d exp 5", i, pc_next); end
            tick();
            checks++;
            if (ifid_pc !== 6'd4 || ifid_instr !== 16'h1004 || ifid_valid !== 1'b1 || fetch_count !== 16'd5) begin
                errors++; $display("FAIL stall_hold_%0d got pc=%0d instr=%h v=%b cnt=%0d exp 4/1004/1/5", i, ifid_pc, ifid_instr, ifid_valid, fetch_count);
            end
        end
        stall = 1'b0;
        tick();
        checks++; if (ifid_pc !== 6'd5 || fetch_count !== 16'd6) begin errors++; $display("FAIL stall_resume got pc=%0d cnt=%0d exp 5/6", ifid_pc, fetch_count); end
    endtask

    task automatic test_branch_stall;
        br_taken = 1'b1; br_target = 6'd20; stall = 1'b1;
        #1;
        checks++; if (pc_next !== 6'd20) begin errors++; $display("FAIL br_pc_next got %0d exp 20", pc_next); end
        tick();
        br_taken = 1'b0; stall = 1'b0;
        checks++; if (ifid_valid !== 1'b0 || fetch_count !== 16'd6) begin errors++; $display("FAIL br_flush got v=%b cnt=%0d exp 0/6", ifid_valid, fetch_count); end
        tick();
        checks++;
        if (ifid_pc !== 6'd20 || ifid_instr !== 16'h1014 || ifid_valid !== 1'b1 || fetch_count !== 16'd7) begin
            errors++; $display("FAIL br_target_fetch got pc=%0d instr=%h v=%b cnt=%0d exp 20/1014/1/7", ifid_pc, ifid_instr, ifid_valid, fetch_count);
        end
    endtask

    task automatic test_wrap;
        br_taken = 1'b1; br_target = 6'd63;
        tick();
        br_taken = 1'b0;
        #1;
        checks++; if (pc_next !== 6'd0) begin errors++; $display("FAIL wrap_pc_next got %0d exp 0", pc_next); end
        tick();
        checks++; if (ifid_pc !== 6'd63 || ifid_instr !== 16'h103F || fetch_count !== 16'd8) begin errors++; $display("FAIL wrap_fetch got pc=%0d instr=%h cnt=%0d exp 63/103f/8", ifid_pc, ifid_instr, fetch_count); end
        checks++; if (pc_cur !== 6'd0) begin errors++; $display("FAIL wrap_pc_reg got %0d exp 0", pc_cur); end
    endtask

    task automatic test_halt;
        br_taken = 1'b1; br_target = 6'd9;
        tick();
        br_taken = 1'b0; stall = 1'b1;
        // HALT word present but stalled: no detection
        tick();
        stall = 1'b0;
        checks++; if (halted !== 1'b0 || ifid_valid !== 1'b0) begin errors++; $display("FAIL halt_stall got halted=%b v=%b exp 0/0", halted, ifid_valid); end
        #1;
        checks++; if (pc_next !== 6'd9) begin errors++; $display("FAIL halt_pc_next got %0d exp 9", pc_next); end
        tick();
        checks++;
        if (ifid_instr !== 16'hF000 || ifid_valid !== 1'b1 || ifid_pc !== 6'd9 || halted !== 1'b1 || fetch_count !== 16'd9) begin
            errors++; $display("FAIL halt_deliver got instr=%h v=%b pc=%0d halted=%b cnt=%0d exp f000/1/9/1/9", ifid_instr, ifid_valid, ifid_pc, halted, fetch_count);
        end
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (pc_next !== 6'd9) begin errors++; $display("FAIL halted_pc_%0d got %0d exp 9", i, pc_next); end
            tick();
            checks++; if (halted !== 1'b1 || ifid_valid !== 1'b0 || fetch_count !== 16'd9) begin errors++; $display("FAIL halted_hold_%0d got halted=%b v=%b cnt=%0d exp 1/0/9", i, halted, ifid_valid, fetch_count); end
        end
        br_taken = 1'b1; br_target = 6'd2;
        #1;
        checks++; if (pc_next !== 6'd2) begin errors++; $display("FAIL unhalt_pc_next got %0d exp 2", pc_next); end
        tick();
        br_taken = 1'b0;
        checks++; if (halted !== 1'b0 || ifid_valid !== 1'b0) begin errors++; $display("FAIL unhalt got halted=%b v=%b exp 0/0", halted, ifid_valid); end
        tick();
        checks++;
        if (ifid_pc !== 6'd2 || ifid_instr !== 16'h1002 || ifid_valid !== 1'b1 || fetch_count !== 16'd10) begin
            errors++; $display("FAIL resume got pc=%0d instr=%h v=%b cnt=%0d exp 2/1002/1/10", ifid_pc, ifid_instr, ifid_valid, fetch_count);
        end
    endtask

    task automatic test_reset_mid_halt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        br_taken = 1'b1; br_target = 6'd9;
        tick();
        br_taken = 1'b0;
        tick();
        tick();
        checks++; if (halted !== 1'b1 || fetch_count !== 16'd7) begin errors++; $display("FAIL prerst got halted=%b cnt=%0d exp 1/7", halted, fetch_count); end
        rst = 1'b1; br_taken = 1'b1; br_target = 6'd30; stall = 1'b1;
        #1;
        checks++; if (pc_next !== 6'd0) begin errors++; $display("FAIL midrst_pc_next got %0d exp 0", pc_next); end
        tick();
        checks++;
        if (halted !== 1'b0 || fetch_count !== 16'd0 || ifid_valid !== 1'b0 || ifid_pc !== 6'd0 || ifid_instr !== 16'h0) begin
            errors++; $display("FAIL midrst got halted=%b cnt=%0d v=%b pc=%0d instr=%h exp 0/0/0/0/0000", halted, fetch_count, ifid_valid, ifid_pc, ifid_instr);
        end
        rst = 1'b0; br_taken = 1'b0; stall = 1'b0;
        tick();
        checks++; if (ifid_pc !== 6'd0 || ifid_valid !== 1'b1 || fetch_count !== 16'd1) begin errors++; $display("FAIL postrst got pc=%0d v=%b cnt=%0d exp 0/1/1", ifid_pc, ifid_valid, fetch_count); end
    endtask

    initial begin
        test_reset();
        test_seq_fetch();
        test_stall();
        test_branch_stall();
        test_wrap();
        test_halt();
        test_reset_mid_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
